// File: rtl/eigen2x2_pkg.sv
// Shared types and helpers for the eigen2x2_mc solver.
// EIGEN2X2_SAT_EN selects saturating output conversion; wrap otherwise.
package eigen2x2_pkg;

  typedef enum logic [2:0] {IDLE, PREP, SQRT, POST, OUT} state_t;

  function automatic int h_w(input int din_w);
    return din_w + 1;
  endfunction

  function automatic int root_w(input int din_w);
    return din_w + 2;
  endfunction

  function automatic int q_w(input int din_w);
    return 2 * (din_w + 2);
  endfunction

  // Positive sh drops fractional bits (floor), negative sh adds them.
  function automatic logic signed [63:0] align_pt(input logic signed [63:0] v, input int sh);
    return (sh >= 0) ? (v >>> sh) : (v <<< (-sh));
  endfunction

  function automatic logic signed [63:0] sat_hi(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

  function automatic logic signed [63:0] cvt_val(input logic signed [63:0] v, input int sh,
                                                 input int dw);
    logic signed [63:0] s;
    s = align_pt(v, sh);
`ifdef EIGEN2X2_SAT_EN
    if (s > sat_hi(dw)) s = sat_hi(dw);
    else if (s < sat_lo(dw)) s = sat_lo(dw);
`else
    s = (s <<< (64 - dw)) >>> (64 - dw);
`endif
    return s;
  endfunction

  function automatic logic cvt_ovf(input logic signed [63:0] v, input int sh, input int dw);
    logic signed [63:0] s;
    s = align_pt(v, sh);
    return (s > sat_hi(dw)) || (s < sat_lo(dw));
  endfunction

endpackage

// File: rtl/eigen2x2_mc_sqrt_iter.sv
// Restoring bit-serial square root: one root bit per cycle, ROOT_W cycles.
// The start cycle already performs the first iteration straight from rad.
module sqrt_iter import eigen2x2_pkg::*; #(
  parameter int ROOT_W = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*ROOT_W-1:0]   rad,
  output logic                  busy,
  output logic                  done,
  output logic [ROOT_W-1:0]     root
);
  localparam int CW = $clog2(ROOT_W + 1);

  logic [2*ROOT_W-1:0] rad_sh, src_rad;
  logic [ROOT_W-1:0]   rem, src_rem, src_rt, nxt_rt;
  logic [ROOT_W+1:0]   rem_sh, trial;
  logic                ge;
  logic [CW-1:0]       cnt;

  always_comb begin
    src_rad = start ? rad : rad_sh;
    src_rem = start ? '0 : rem;
    src_rt  = start ? '0 : root;
    rem_sh  = {src_rem, src_rad[2*ROOT_W-1 -: 2]};
    trial   = {src_rt, 2'b01};
    ge      = rem_sh >= trial;
    nxt_rt  = {src_rt[ROOT_W-2:0], ge};
  end

  // Partial remainder never exceeds ROOT_W bits before a step; the
  // final remainder is discarded, so truncation is safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      root   <= '0;
      rad_sh <= '0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        rad_sh <= {src_rad[2*ROOT_W-3:0], 2'b00};
        rem    <= ROOT_W'(ge ? rem_sh - trial : rem_sh);
        root   <= nxt_rt;
      end
      if (start) begin
        busy <= 1'b1;
        cnt  <= CW'(1);
      end else if (busy) begin
        cnt <= cnt + CW'(1);
        if (cnt == CW'(ROOT_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eigen2x2_mc.sv
// Handshaked multi-channel 2x2 symmetric eigen solver with iterative sqrt.
// EIGEN2X2_SAT_EN: saturate outputs and flag dout_ovf; otherwise wrap.
module eigen2x2_mc import eigen2x2_pkg::*; #(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_POINT  = 15,
  parameter int DOUT_WIDTH = 16,
  parameter int DOUT_POINT = 13,
  parameter int CH_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [CH_WIDTH-1:0]   din_ch,
  input  logic [DIN_WIDTH-1:0]  r11,
  input  logic [DIN_WIDTH-1:0]  r22,
  input  logic [DIN_WIDTH-1:0]  r12,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [CH_WIDTH-1:0]   dout_ch,
  output logic [DOUT_WIDTH-1:0] lamb1,
  output logic [DOUT_WIDTH-1:0] lamb2,
  output logic [DOUT_WIDTH-1:0] eigen_x,
  output logic [DOUT_WIDTH-1:0] eigen1_y,
  output logic [DOUT_WIDTH-1:0] eigen2_y,
  output logic                  dout_ovf
);
  localparam int H_W    = h_w(DIN_WIDTH);
  localparam int ROOT_W = root_w(DIN_WIDTH);
  localparam int Q_W    = q_w(DIN_WIDTH);
  localparam int FW     = DIN_WIDTH + 4;
  localparam int SH     = DIN_POINT + 1 - DOUT_POINT;

  state_t                       state;
  logic [CH_WIDTH-1:0]          ch_q;
  logic [DIN_WIDTH-1:0]         r11_q, r22_q;
  logic signed [DIN_WIDTH-1:0]  r12_q;
  logic [H_W-1:0]               h_q, h_nxt;
  logic [Q_W-1:0]               q_q, q_nxt;
  logic signed [H_W-1:0]        d;
  logic signed [2*H_W-1:0]      d_sq;
  logic signed [2*DIN_WIDTH-1:0] r12_sq;
  logic                         sq_start, sq_busy, sq_done;
  logic [ROOT_W-1:0]            sq_root;
  logic signed [FW-1:0]         h_f, root_f, r11_f, x_f, l1_f, l2_f, y1_f, y2_f;

  assign din_ready = (state == IDLE) && !rst;
  assign sq_start  = (state == SQRT) && !sq_busy && !sq_done;

  // h and d carry one extra fractional bit so the halving is exact.
  always_comb begin
    h_nxt  = {1'b0, r11_q} + {1'b0, r22_q};
    d      = signed'({1'b0, r11_q}) - signed'({1'b0, r22_q});
    d_sq   = (2*H_W)'(d) * (2*H_W)'(d);
    r12_sq = (2*DIN_WIDTH)'(r12_q) * (2*DIN_WIDTH)'(r12_q);
    q_nxt  = Q_W'(unsigned'(d_sq)) + (Q_W'(unsigned'(r12_sq)) << 2);
  end

  always_comb begin
    h_f    = signed'(FW'(h_q));
    root_f = signed'(FW'(sq_root));
    r11_f  = signed'(FW'({r11_q, 1'b0}));
    x_f    = signed'(FW'(r12_q)) <<< 1;
    l1_f   = h_f + root_f;
    l2_f   = h_f - root_f;
    y1_f   = l1_f - r11_f;
    y2_f   = l2_f - r11_f;
  end

  sqrt_iter #(.ROOT_W(ROOT_W)) u_sqrt (
    .clk   (clk),
    .rst   (rst),
    .start (sq_start),
    .rad   (q_q),
    .busy  (sq_busy),
    .done  (sq_done),
    .root  (sq_root)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ch_q       <= '0;
      r11_q      <= '0;
      r22_q      <= '0;
      r12_q      <= '0;
      h_q        <= '0;
      q_q        <= '0;
      dout_valid <= 1'b0;
      dout_ch    <= '0;
      lamb1      <= '0;
      lamb2      <= '0;
      eigen_x    <= '0;
      eigen1_y   <= '0;
      eigen2_y   <= '0;
      dout_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (din_valid) begin
          ch_q  <= din_ch;
          r11_q <= r11;
          r22_q <= r22;
          r12_q <= r12;
          state <= PREP;
        end
        PREP: begin
          h_q   <= h_nxt;
          q_q   <= q_nxt;
          state <= SQRT;
        end
        SQRT: if (sq_done) state <= POST;
        POST: begin
          lamb1    <= DOUT_WIDTH'(cvt_val(64'(l1_f), SH, DOUT_WIDTH));
          lamb2    <= DOUT_WIDTH'(cvt_val(64'(l2_f), SH, DOUT_WIDTH));
          eigen_x  <= DOUT_WIDTH'(cvt_val(64'(x_f), SH, DOUT_WIDTH));
          eigen1_y <= DOUT_WIDTH'(cvt_val(64'(y1_f), SH, DOUT_WIDTH));
          eigen2_y <= DOUT_WIDTH'(cvt_val(64'(y2_f), SH, DOUT_WIDTH));
`ifdef EIGEN2X2_SAT_EN
          dout_ovf <= cvt_ovf(64'(l1_f), SH, DOUT_WIDTH) | cvt_ovf(64'(l2_f), SH, DOUT_WIDTH) |
                      cvt_ovf(64'(x_f), SH, DOUT_WIDTH)  | cvt_ovf(64'(y1_f), SH, DOUT_WIDTH) |
                      cvt_ovf(64'(y2_f), SH, DOUT_WIDTH);
`else
          dout_ovf <= 1'b0;
`endif
          dout_ch    <= ch_q;
          dout_valid <= 1'b1;
          state      <= OUT;
        end
        OUT: if (dout_ready) begin
          dout_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eigen2x2_mc.sv
// Randomized bench for eigen2x2_mc: two instances (Q.13 and Q.14 outputs)
// share stimulus and are compared against a real-arithmetic eigen model.
module tb_eigen2x2_mc;
  logic        clk = 1'b0;
  logic        rst, din_valid, dout_ready;
  logic [3:0]  din_ch;
  logic [15:0] r11, r22, r12;
  logic        din_ready, dout_valid, dout_ovf;
  logic [3:0]  dout_ch;
  logic [15:0] lamb1, lamb2, eigen_x, eigen1_y, eigen2_y;
  logic        din_ready_b, dout_valid_b, dout_ovf_b;
  logic [3:0]  dout_ch_b;
  logic [15:0] lamb1_b, lamb2_b, eigen_x_b, eigen1_y_b, eigen2_y_b;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  eigen2x2_mc u_dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready), .din_ch(din_ch),
    .r11(r11), .r22(r22), .r12(r12), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_ch(dout_ch), .lamb1(lamb1), .lamb2(lamb2), .eigen_x(eigen_x),
    .eigen1_y(eigen1_y), .eigen2_y(eigen2_y), .dout_ovf(dout_ovf));

  eigen2x2_mc #(.DOUT_POINT(14)) u_dut14 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready_b), .din_ch(din_ch),
    .r11(r11), .r22(r22), .r12(r12), .dout_valid(dout_valid_b), .dout_ready(dout_ready),
    .dout_ch(dout_ch_b), .lamb1(lamb1_b), .lamb2(lamb2_b), .eigen_x(eigen_x_b),
    .eigen1_y(eigen1_y_b), .eigen2_y(eigen2_y_b), .dout_ovf(dout_ovf_b));

  typedef struct packed {
    logic [15:0] l1, l2, x, y1, y2;
    logic        ovf;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint isqrt(input longint q);
    longint r;
    r = longint'($floor($sqrt(real'(q))));
    while (r * r > q) r--;
    while ((r + 1) * (r + 1) <= q) r++;
    return r;
  endfunction

  // Eigen decomposition from the closed form, evaluated in reals; the only
  // integer step is the floor of the root at 16 fractional bits.
  function automatic exp_t model(input int a, input int b, input int c, input int dp);
    exp_t        e;
    longint      dd, q, rt, iv;
    real         h, root, r11r, xr;
    real         vals[5];
    logic [15:0] o[5];
    dd   = longint'(a - b);
    q    = dd * dd + 4 * longint'(c) * longint'(c);
    rt   = isqrt(q);
    h    = (a + b) / 65536.0;
    root = rt / 65536.0;
    r11r = a / 32768.0;
    xr   = c / 32768.0;
    vals[0] = h + root;
    vals[1] = h - root;
    vals[2] = xr;
    vals[3] = h + root - r11r;
    vals[4] = h - root - r11r;
    e.ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iv = longint'($floor(vals[i] * (2.0 ** dp)));
`ifdef EIGEN2X2_SAT_EN
      if (iv > 32767) begin iv = 32767; e.ovf = 1'b1; end
      else if (iv < -32768) begin iv = -32768; e.ovf = 1'b1; end
`endif
      o[i] = iv[15:0];
    end
    e.l1 = o[0]; e.l2 = o[1]; e.x = o[2]; e.y1 = o[3]; e.y2 = o[4];
    return e;
  endfunction

  task automatic check_out(input exp_t ea, input exp_t eb, input logic [3:0] ch, input string p);
    chk({p, ":ch"},    32'(dout_ch),    32'(ch));
    chk({p, ":l1"},    32'(lamb1),      32'(ea.l1));
    chk({p, ":l2"},    32'(lamb2),      32'(ea.l2));
    chk({p, ":x"},     32'(eigen_x),    32'(ea.x));
    chk({p, ":y1"},    32'(eigen1_y),   32'(ea.y1));
    chk({p, ":y2"},    32'(eigen2_y),   32'(ea.y2));
    chk({p, ":ovf"},   32'(dout_ovf),   32'(ea.ovf));
    chk({p, ":ch14"},  32'(dout_ch_b),  32'(ch));
    chk({p, ":l1_14"}, 32'(lamb1_b),    32'(eb.l1));
    chk({p, ":l2_14"}, 32'(lamb2_b),    32'(eb.l2));
    chk({p, ":x14"},   32'(eigen_x_b),  32'(eb.x));
    chk({p, ":y1_14"}, 32'(eigen1_y_b), 32'(eb.y1));
    chk({p, ":y2_14"}, 32'(eigen2_y_b), 32'(eb.y2));
    chk({p, ":ovf14"}, 32'(dout_ovf_b), 32'(eb.ovf));
  endtask

  task automatic run_txn(input logic [3:0] ch, input int a, input int b, input int c,
                         input int hold);
    exp_t ea, eb;
    int   k;
    ea = model(a, b, c, 13);
    eb = model(a, b, c, 14);
    @(negedge clk);
    k = 0;
    while (!din_ready && k < 100) begin @(negedge clk); k++; end
    chk("in_rdy", 32'(din_ready), 32'd1);
    din_valid = 1'b1; din_ch = ch;
    r11 = a[15:0]; r22 = b[15:0]; r12 = c[15:0];
    @(posedge clk); #1;
    din_valid = 1'b0;
    k = 0;
    while (k < 40) begin
      @(posedge clk); #1; k++;
      if (dout_valid) break;
    end
    chk("latency", 32'(k), 32'd21);
    chk("lat14", 32'(dout_valid_b), 32'd1);
    check_out(ea, eb, ch, "res");
    // Under backpressure a new request is offered and must be ignored.
    for (int i = 0; i < hold; i++) begin
      din_valid = 1'b1; r11 = 16'($urandom); r12 = 16'($urandom);
      chk("bp_rdy", 32'(din_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp_vld", 32'(dout_valid), 32'd1);
      check_out(ea, eb, ch, "hold");
    end
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0; din_valid = 1'b0;
    chk("hs_vld", 32'(dout_valid), 32'd0);
    chk("hs_rdy", 32'(din_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cnt, a, b, c;
    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
    din_ch = '0; r11 = '0; r22 = '0; r12 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 32'(dout_valid), 32'd0);
    chk("rst_rdy", 32'(din_ready), 32'd0);
    chk("rst_l1", 32'(lamb1), 32'd0);
    chk("rst_ch", 32'(dout_ch), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rdy_up", 32'(din_ready), 32'd1);

    run_txn(4'd3, 32'h4000, 32'h4000, 0, 0);
    chk("tp1_l1", 32'(lamb1), 32'h1000);
    chk("tp1_l2", 32'(lamb2), 32'h1000);
    chk("tp1_y2", 32'(eigen2_y), 32'h0);
    run_txn(4'd5, 32'h4000, 0, 0, 0);
    chk("tp2_l1", 32'(lamb1), 32'h1000);
    chk("tp2_y2", 32'(eigen2_y), 32'hF000);
    run_txn(4'd7, 32'h2000, 32'h2000, 32'h2000, 10);
    chk("tp3_x", 32'(eigen_x), 32'h0800);
    chk("tp3_y1", 32'(eigen1_y), 32'h0800);
    chk("tp3_y2", 32'(eigen2_y), 32'hF800);
    run_txn(4'd9, 32'hFFFF, 32'hFFFF, 32'h7FFF, 1);
`ifdef EIGEN2X2_SAT_EN
    chk("sat_l1", 32'(lamb1_b), 32'h7FFF);
    chk("sat_ovf", 32'(dout_ovf_b), 32'd1);
`else
    chk("wrap_l1", 32'(lamb1_b), 32'hBFFF);
    chk("wrap_ovf", 32'(dout_ovf_b), 32'd0);
`endif
    run_txn(4'd1, 32'hFFFF, 0, -32768, 0);

    // Abort a transaction mid-sqrt.
    @(negedge clk);
    din_valid = 1'b1; din_ch = 4'd6; r11 = 16'h1234; r22 = 16'h0F00; r12 = 16'h0444;
    @(posedge clk); #1 din_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_vld", 32'(dout_valid), 32'd0);
    chk("abort_l1", 32'(lamb1), 32'd0);
    chk("abort_x", 32'(eigen_x), 32'd0);
    chk("abort_ch", 32'(dout_ch), 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 chk("abort_rdy", 32'(din_ready), 32'd1);
    cnt = 0;
    repeat (25) begin @(posedge clk); #1; if (dout_valid || dout_valid_b) cnt++; end
    chk("abort_stale", 32'(cnt), 32'd0);
    run_txn(4'd2, 32'h3000, 32'h1000, -4096, 0);

    for (int t = 0; t < 25; t++) begin
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      c = int'($urandom_range(0, 65535)) - 32768;
      run_txn(4'($urandom), a, b, c, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
